spi_master_param: RTL and testbench

Parametrised SPI master engine replacing the fixed 8-bit, single-select sender behind the AXI-Lite register bank. It performs one DATA_W-bit full-duplex frame per `start`, in any of the four CPOL/CPHA modes, with MSB- or LSB-first order. It has a programmable SCK divider, NUM_CS one-hot chip selects, and chip-select hold between frames for multi-frame memory sequences such as command, address and data. All logic runs on the rising edge of `clk`.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_master_param_if.sv | 32 +++
 rtl/spi_sck_gen.sv | 54 +++++
 rtl/spi_master_param.sv | 167 ++++++++++++++++
 tb/tb_spi_master_param.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the parametrised SPI master engine.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HELD,
        ST_CSS,
        ST_XFER,
        ST_CSH,
        ST_GAP
    } spi_state_e;

    // Mode number is {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam int CSS_CYC_DEF = 3;
    localparam int CSH_CYC_DEF = 5;

endpackage

// File: rtl/spi_master_param_if.sv
// Host-side request/response bundle of the SPI master engine.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1,
    parameter int DIV_W  = 8
);
    localparam int SEL_W = $clog2(NUM_CS) + 1;

    logic              start;
    logic              hold_cs;
    logic [SEL_W-1:0]  cs_sel;
    logic [DIV_W-1:0]  clk_div;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              ready;
    logic              cs_held;

    modport master (
        output start, hold_cs, cs_sel, clk_div, cpol, cpha, lsb_first, tx_data,
        input  rx_data, rx_valid, ready, cs_held
    );

    modport slave (
        input  start, hold_cs, cs_sel, clk_div, cpol, cpha, lsb_first, tx_data,
        output rx_data, rx_valid, ready, cs_held
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider: half-period counter, edge counter, leading/trailing strobes
// and the registered serial clock.
module spi_sck_gen #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_cpol,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_lead_stb,
    output logic             o_trail_stb,
    output logic             o_last,
    output logic             o_sck
);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    logic [DIV_W-1:0]  r_cnt;
    logic [EDGE_W-1:0] r_edge;
    logic              r_sck;
    logic              w_tick;

    // Strobes fire in the cycle before the toggled sck becomes visible
    assign w_tick      = i_en && (r_cnt == i_div);
    assign o_lead_stb  = w_tick && !r_edge[0];
    assign o_trail_stb = w_tick && r_edge[0];
    assign o_last      = w_tick && (r_edge == EDGE_W'(2 * DATA_W - 1));
    assign o_sck       = r_sck;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt  <= '0;
            r_edge <= '0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_edge <= r_edge + 1'b1;
        end else if (i_en) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_sck <= 1'b0;
        else if (i_load)
            r_sck <= i_cpol;
        else if (w_tick)
            r_sck <= ~r_sck;
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W-bit full-duplex frame per start, any
// CPOL/CPHA mode, MSB/LSB first, one-hot selects with CS hold between frames.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 1,
    parameter int DIV_W   = 8,
    parameter int CSS_CYC = CSS_CYC_DEF,
    parameter int CSH_CYC = CSH_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_param_if.slave   io_bus,
    output logic                o_sck,
    output logic [NUM_CS-1:0]   o_cs_n,
    output logic                o_mosi,
    input  logic                i_miso
);
    localparam int SEL_W  = $clog2(NUM_CS) + 1;
    localparam int WMAX   = (CSS_CYC > CSH_CYC) ? CSS_CYC : CSH_CYC;
    localparam int WAIT_W = $clog2(WMAX + 1);

    spi_state_e        r_state, w_state_nx;
    logic [WAIT_W-1:0] r_wait;
    logic [SEL_W-1:0]  r_sel, r_sel_pend, w_sel_e;
    spi_mode_e         r_mode;
    logic              r_lsb, r_hold, r_restart;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
    logic              r_rx_valid, r_mosi;
    logic [NUM_CS-1:0] r_cs_n;

    logic              w_idle, w_ready, w_accept, w_same_sel, w_in_xfer;
    logic              w_lead, w_trail, w_last, w_cpha;
    logic              w_css_entry, w_xfer_entry, w_held_xfer, w_cs_active;
    logic              w_lsb_e, w_cpha_e, w_first_drv, w_shift_drv, w_drive;
    logic              w_sample, w_tx_bit;
    logic [DATA_W-1:0] w_tx_src, w_tx_shift, w_rx_nx;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (sel == SEL_W'(i))
                v[i] = 1'b0;
        return v;
    endfunction

    // A frame-end cycle never accepts, so a start there is dropped
    assign w_idle     = (r_state == ST_IDLE) || (r_state == ST_HELD);
    assign w_ready    = w_idle && !rst && !r_rx_valid;
    assign w_accept   = w_ready && io_bus.start;
    assign w_same_sel = (io_bus.cs_sel == r_sel);
    assign w_in_xfer  = (r_state == ST_XFER);
    assign w_cpha     = (r_mode == MODE1) || (r_mode == MODE3);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nx = ST_CSS;
            ST_HELD: if (w_accept) w_state_nx = w_same_sel ? ST_XFER : ST_CSH;
            ST_CSS:  if (r_wait == WAIT_W'(CSS_CYC - 1)) w_state_nx = ST_XFER;
            ST_XFER: if (w_last) w_state_nx = r_hold ? ST_HELD : ST_CSH;
            ST_CSH:  if (r_wait == WAIT_W'(CSH_CYC - 1)) w_state_nx = ST_GAP;
            ST_GAP:  w_state_nx = r_restart ? ST_CSS : ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_css_entry  = (w_state_nx == ST_CSS) && (r_state != ST_CSS);
    assign w_xfer_entry = (w_state_nx == ST_XFER) && !w_in_xfer;
    assign w_held_xfer  = (r_state == ST_HELD) && (w_state_nx == ST_XFER);
    assign w_cs_active  = (w_state_nx == ST_CSS) || (w_state_nx == ST_XFER) ||
                          (w_state_nx == ST_HELD) || (w_state_nx == ST_CSH);
    assign w_sel_e      = w_accept ? io_bus.cs_sel : r_sel_pend;

    // Frame parameters come straight from the bus in the accepting cycle
    assign w_tx_src    = w_accept ? io_bus.tx_data   : r_tx;
    assign w_lsb_e     = w_accept ? io_bus.lsb_first : r_lsb;
    assign w_cpha_e    = w_accept ? io_bus.cpha      : w_cpha;
    assign w_tx_bit    = w_lsb_e ? w_tx_src[0] : w_tx_src[DATA_W-1];
    assign w_tx_shift  = w_lsb_e ? (w_tx_src >> 1) : (w_tx_src << 1);
    assign w_first_drv = !w_cpha_e && (w_css_entry || w_held_xfer);
    assign w_shift_drv = w_in_xfer && (w_cpha ? w_lead : (w_trail && !w_last));
    assign w_drive     = w_first_drv || w_shift_drv;

    assign w_sample = w_in_xfer && (w_cpha ? w_trail : w_lead);
    assign w_rx_nx  = !w_sample ? r_rx :
                      r_lsb     ? {i_miso, r_rx[DATA_W-1:1]} :
                                  {r_rx[DATA_W-2:0], i_miso};

    spi_sck_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_sck_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_cpol      (io_bus.cpol),
        .i_clear     (w_xfer_entry),
        .i_en        (w_in_xfer),
        .i_div       (r_div),
        .o_lead_stb  (w_lead),
        .o_trail_stb (w_trail),
        .o_last      (w_last),
        .o_sck       (o_sck)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait     <= '0;
            r_sel      <= '0;
            r_sel_pend <= '0;
            r_mode     <= MODE0;
            r_lsb      <= 1'b0;
            r_hold     <= 1'b0;
            r_div      <= '0;
            r_restart  <= 1'b0;
            r_cs_n     <= '1;
            r_mosi     <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx != r_state)
                r_wait <= '0;
            else if ((r_state == ST_CSS) || (r_state == ST_CSH))
                r_wait <= r_wait + 1'b1;
            if (w_accept) begin
                r_sel_pend <= io_bus.cs_sel;
                r_mode     <= spi_mode_e'({io_bus.cpol, io_bus.cpha});
                r_lsb      <= io_bus.lsb_first;
                r_hold     <= io_bus.hold_cs;
                r_div      <= io_bus.clk_div;
            end
            if (w_css_entry)
                r_restart <= 1'b0;
            else if (w_accept && (r_state == ST_HELD) && !w_same_sel)
                r_restart <= 1'b1;
            if (w_css_entry)
                r_sel <= w_sel_e;
            r_cs_n <= w_cs_active ? cs_decode(w_css_entry ? w_sel_e : r_sel) : '1;
            if (w_drive)
                r_mosi <= w_tx_bit;
            else if (w_in_xfer && w_last)
                r_mosi <= 1'b1;
            r_rx_valid <= w_in_xfer && w_last;
            if (w_in_xfer && w_last)
                r_rx_data <= w_rx_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_tx <= w_drive ? w_tx_shift : w_tx_src;
        r_rx <= w_rx_nx;
    end

    assign o_cs_n          = r_cs_n;
    assign o_mosi          = r_mosi;
    assign io_bus.rx_data  = r_rx_data;
    assign io_bus.rx_valid = r_rx_valid;
    assign io_bus.ready    = w_ready;
    assign io_bus.cs_held  = (r_state == ST_HELD);

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param (DATA_W=8, NUM_CS=4).
module tb_spi_master_param;
    import spi_pkg::*;

    logic       clk;
    logic       rst;
    logic       sck;
    logic [3:0] cs_n;
    logic       mosi;
    logic       miso;
    logic       lpbk;
    logic       miso_val;
    int         checks;
    int         errors;
    logic [7:0] burst_tx [4];

    spi_master_param_if #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) bus ();

    spi_master_param #(
        .DATA_W (8),
        .NUM_CS (4),
        .DIV_W  (8),
        .CSS_CYC(3),
        .CSH_CYC(5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus),
        .o_sck  (sck),
        .o_cs_n (cs_n),
        .o_mosi (mosi),
        .i_miso (miso)
    );

    assign miso = lpbk ? mosi : miso_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit to);
        int n;
        n = 0;
        while (!bus.ready && n < 200) begin
            tick();
            n++;
        end
        to = !bus.ready;
    endtask

    task automatic start_frame(input logic [2:0] sel, input logic [7:0] div,
                               input logic pol, input logic pha, input logic lsb,
                               input logic hold, input logic [7:0] tx);
        bus.cs_sel    = sel;
        bus.clk_div   = div;
        bus.cpol      = pol;
        bus.cpha      = pha;
        bus.lsb_first = lsb;
        bus.hold_cs   = hold;
        bus.tx_data   = tx;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n got %h want f", cs_n); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b want 1", mosi); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        checks++; if (bus.cs_held !== 1'b0) begin errors++; $display("FAIL reset_cs_held got %b want 0", bus.cs_held); end
        rst = 1'b0;
        tick();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", bus.ready); end
    endtask

    task automatic test_mode0_loopback();
        int first_edge, edges, pulses, rxv_c, cs_hi_c;
        logic prev, rdy;
        logic [7:0] rxd;
        bit to;
        first_edge = 0; edges = 0; pulses = 0; rxv_c = 0; cs_hi_c = 0;
        rdy = 1'bx; rxd = 8'hxx;
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL m0_ready_timeout got 0 want 1"); end
        lpbk = 1'b1;
        start_frame(3'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
        checks++; if (cs_n !== 4'b1110) begin errors++; $display("FAIL m0_cs_assert got %b want 1110", cs_n); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL m0_first_bit got %b want 1", mosi); end
        prev = sck;
        for (int c = 2; c <= 50; c++) begin
            tick();
            if (sck !== prev) begin
                edges++;
                if (first_edge == 0) first_edge = c;
            end
            prev = sck;
            if (bus.rx_valid) begin
                pulses++;
                rxv_c = c;
                rxd = bus.rx_data;
                rdy = bus.ready;
            end
            if (cs_n == 4'hF && cs_hi_c == 0) cs_hi_c = c;
        end
        checks++; if (first_edge != 6) begin errors++; $display("FAIL m0_first_edge got %0d want 6", first_edge); end
        checks++; if (edges != 16) begin errors++; $display("FAIL m0_edges got %0d want 16", edges); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL m0_pulses got %0d want 1", pulses); end
        checks++; if (rxv_c != 36) begin errors++; $display("FAIL m0_rx_valid_cycle got %0d want 36", rxv_c); end
        checks++; if (rxd !== 8'hA5) begin errors++; $display("FAIL m0_rx_data got %h want a5", rxd); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL m0_ready_at_end got %b want 0", rdy); end
        checks++; if (cs_hi_c != 41) begin errors++; $display("FAIL m0_cs_release got %0d want 41", cs_hi_c); end
    endtask

    task automatic test_mode3_lsb();
        int c;
        bit to;
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL m3_ready_timeout got 0 want 1"); end
        lpbk = 1'b0;
        miso_val = 1'b1;
        start_frame(3'd0, 8'd0, MODE3 >> 1, 1'b1, 1'b1, 1'b0, 8'h01);
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL m3_sck_idle got %b want 1", sck); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL m3_mosi_idle got %b want 1", mosi); end
        repeat (4) tick();
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL m3_edge1_sck got %b want 0", sck); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL m3_bit0 got %b want 1", mosi); end
        repeat (2) tick();
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL m3_bit1 got %b want 0", mosi); end
        c = 7;
        while (!bus.rx_valid && c < 100) begin
            tick();
            c++;
        end
        checks++; if (c != 20) begin errors++; $display("FAIL m3_rx_valid_cycle got %0d want 20", c); end
        checks++; if (bus.rx_data !== 8'hFF) begin errors++; $display("FAIL m3_rx_data got %h want ff", bus.rx_data); end
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL m3_sck_end got %b want 1", sck); end
    endtask

    task automatic test_burst();
        int pulses, lat;
        bit broke, to;
        pulses = 0;
        broke = 1'b0;
        burst_tx[0] = 8'h03; burst_tx[1] = 8'h00; burst_tx[2] = 8'h10; burst_tx[3] = 8'h00;
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL burst_ready_timeout got 0 want 1"); end
        lpbk = 1'b1;
        for (int f = 0; f < 4; f++) begin
            start_frame(3'd0, 8'd0, 1'b0, 1'b0, 1'b0, (f < 3), burst_tx[f]);
            lat = 1;
            while (!bus.rx_valid && lat < 100) begin
                if (cs_n[0]) broke = 1'b1;
                tick();
                lat++;
            end
            if (cs_n[0]) broke = 1'b1;
            checks++;
            if (!bus.rx_valid) begin
                errors++; $display("FAIL burst_rx_timeout frame %0d got 0 want 1", f);
            end else begin
                pulses++;
                checks++; if (bus.rx_data !== burst_tx[f]) begin errors++; $display("FAIL burst_rx_data frame %0d got %h want %h", f, bus.rx_data, burst_tx[f]); end
                checks++; if (lat != ((f == 0) ? 20 : 17)) begin errors++; $display("FAIL burst_latency frame %0d got %0d want %0d", f, lat, (f == 0) ? 20 : 17); end
            end
            if (f < 3) begin
                tick();
                if (cs_n[0]) broke = 1'b1;
                checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL burst_pulse_width frame %0d got %b want 0", f, bus.rx_valid); end
                checks++; if (bus.cs_held !== 1'b1) begin errors++; $display("FAIL burst_cs_held frame %0d got %b want 1", f, bus.cs_held); end
                checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL burst_ready frame %0d got %b want 1", f, bus.ready); end
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL burst_pulses got %0d want 4", pulses); end
        checks++; if (broke) begin errors++; $display("FAIL burst_cs_continuity got 1 want 0"); end
    endtask

    task automatic test_cs_switch();
        int c;
        bit to;
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL sw_ready_timeout got 0 want 1"); end
        lpbk = 1'b1;
        start_frame(3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96);
        c = 1;
        while (!bus.rx_valid && c < 100) begin
            tick();
            c++;
        end
        tick();
        checks++; if (bus.cs_held !== 1'b1) begin errors++; $display("FAIL sw_held got %b want 1", bus.cs_held); end
        checks++; if (cs_n !== 4'b1101) begin errors++; $display("FAIL sw_cs_held got %b want 1101", cs_n); end
        start_frame(3'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        repeat (4) tick();
        checks++; if (cs_n !== 4'b1101) begin errors++; $display("FAIL sw_csh got %b want 1101", cs_n); end
        tick();
        checks++; if (cs_n !== 4'b1111) begin errors++; $display("FAIL sw_gap got %b want 1111", cs_n); end
        tick();
        checks++; if (cs_n !== 4'b1011) begin errors++; $display("FAIL sw_new_sel got %b want 1011", cs_n); end
        c = 7;
        while (!bus.rx_valid && c < 100) begin
            tick();
            c++;
        end
        checks++; if (c != 26) begin errors++; $display("FAIL sw_rx_valid_cycle got %0d want 26", c); end
        checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL sw_rx_data got %h want 5a", bus.rx_data); end
    endtask

    task automatic test_reset_mid();
        int c, edges;
        bit saw, to;
        logic prev;
        saw = 1'b0;
        edges = 0;
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL rm_ready_timeout got 0 want 1"); end
        lpbk = 1'b1;
        start_frame(3'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
        prev = sck;
        c = 1;
        while (edges < 7 && c < 200) begin
            tick();
            c++;
            if (sck !== prev) edges++;
            prev = sck;
            if (bus.rx_valid) saw = 1'b1;
        end
        checks++; if (c != 18) begin errors++; $display("FAIL rm_edge7_cycle got %0d want 18", c); end
        rst = 1'b1;
        tick();
        checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL rm_cs_n got %h want f", cs_n); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rm_sck got %b want 0", sck); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rm_mosi got %b want 1", mosi); end
        tick();
        if (bus.rx_valid) saw = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.rx_valid) saw = 1'b1;
        end
        checks++; if (saw) begin errors++; $display("FAIL rm_no_rx_valid got 1 want 0"); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", bus.ready); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data got %h want 00", bus.rx_data); end
    endtask

    task automatic test_start_ignored();
        int c, pulses, rxv_c;
        logic [7:0] rxd;
        bit to;
        pulses = 0;
        rxv_c = 0;
        rxd = 8'hxx;
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL ign_ready_timeout got 0 want 1"); end
        lpbk = 1'b1;
        start_frame(3'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
        c = 1;
        while (c < 12) begin
            tick();
            c++;
        end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ign_ready_busy got %b want 0", bus.ready); end
        bus.tx_data = 8'hFF;
        bus.cs_sel  = 3'd1;
        bus.start   = 1'b1;
        tick();
        c++;
        bus.start   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rx_valid) begin
                pulses++;
                rxv_c = c;
                rxd = bus.rx_data;
            end
            tick();
            c++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", pulses); end
        checks++; if (rxv_c != 36) begin errors++; $display("FAIL ign_rx_valid_cycle got %0d want 36", rxv_c); end
        checks++; if (rxd !== 8'h3C) begin errors++; $display("FAIL ign_rx_data got %h want 3c", rxd); end
        checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL ign_cs_idle got %h want f", cs_n); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        lpbk          = 1'b0;
        miso_val      = 1'b0;
        bus.start     = 1'b0;
        bus.hold_cs   = 1'b0;
        bus.cs_sel    = '0;
        bus.clk_div   = '0;
        bus.cpol      = 1'b0;
        bus.cpha      = 1'b0;
        bus.lsb_first = 1'b0;
        bus.tx_data   = '0;
        test_reset();
        test_mode0_loopback();
        test_mode3_lsb();
        test_burst();
        test_cs_switch();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
